cook_timer_controller: RTL and testbench

- Sequences the oven's cook timer.
- Collects BCD digits from the keypad encoder into an MM:SS setpoint and counts it down on the 1 Hz strobe.
- Drives the magnetron enable and applies the door interlock.
- Sits between the keypad/1 Hz front-end and the display/power stage. It owns all time state and operating mode.

---
 rtl/cook_timer_controller.sv | 166 ++++++++++++++++
 tb/tb_cook_timer_controller.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cook_timer_controller.sv
// Oven cook timer: keypad digit entry into MM:SS, 1 Hz BCD countdown,
// magnetron enable with door interlock, and a timed cook-complete indication.
module cook_timer_controller #(
    parameter int unsigned DONE_HOLD = 3
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    input  logic       tick_1hz,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       magnetron_on,
    output logic       done,
    output logic [2:0] mode
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENTRY = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_N = 4'(DONE_HOLD);

    state_t     state_q;
    logic [3:0] mt_q, mo_q, st_q, so_q;
    logic [2:0] cnt_q;
    logic [3:0] hold_q;
    logic       mag_q, done_q;

    logic [3:0] mt_d, mo_d, st_d, so_d;
    logic       key_ok, time_zero, dec_zero;

    assign key_ok    = key_valid && (key_digit <= 4'd9);
    assign time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
    assign dec_zero  = ({mt_d, mo_d, st_d, so_d} == 16'h0000);

    // One-second BCD decrement; a seconds borrow always reloads tens with 5,
    // so entered values above 59 count down literally until the first borrow.
    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (so_q != 4'd0) begin
            so_d = so_q - 4'd1;
        end else begin
            so_d = 4'd9;
            if (st_q != 4'd0) begin
                st_d = st_q - 4'd1;
            end else begin
                st_d = 4'd5;
                if (mo_q != 4'd0) begin
                    mo_d = mo_q - 4'd1;
                end else begin
                    mo_d = 4'd9;
                    mt_d = mt_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            cnt_q   <= 3'd0;
            hold_q  <= 4'd0;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stop_clear || !door_closed || start) begin
                        // higher-priority events swallow any key this cycle
                    end else if (key_ok) begin
                        {mt_q, mo_q, st_q, so_q} <= {mo_q, st_q, so_q, key_digit};
                        cnt_q   <= 3'd1;
                        state_q <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (stop_clear) begin
                        {mt_q, mo_q, st_q, so_q} <= 16'h0000;
                        cnt_q   <= 3'd0;
                        state_q <= S_IDLE;
                    end else if (!door_closed) begin
                    end else if (start) begin
                        if (!time_zero) begin
                            cnt_q   <= 3'd0;
                            mag_q   <= 1'b1;
                            state_q <= S_COOK;
                        end
                    end else if (key_ok && cnt_q < 3'd4) begin
                        {mt_q, mo_q, st_q, so_q} <= {mo_q, st_q, so_q, key_digit};
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_COOK: begin
                    if (stop_clear || !door_closed) begin
                        mag_q   <= 1'b0;
                        state_q <= S_PAUSE;
                    end else if (tick_1hz && !time_zero) begin
                        {mt_q, mo_q, st_q, so_q} <= {mt_d, mo_d, st_d, so_d};
                        if (dec_zero) begin
                            mag_q   <= 1'b0;
                            done_q  <= 1'b1;
                            hold_q  <= 4'd0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (stop_clear) begin
                        {mt_q, mo_q, st_q, so_q} <= 16'h0000;
                        state_q <= S_IDLE;
                    end else if (!door_closed) begin
                    end else if (start) begin
                        mag_q   <= 1'b1;
                        state_q <= S_COOK;
                    end
                end
                S_DONE: begin
                    if (stop_clear) begin
                        done_q  <= 1'b0;
                        hold_q  <= 4'd0;
                        state_q <= S_IDLE;
                    end else if (tick_1hz) begin
                        if (hold_q + 4'd1 == HOLD_N) begin
                            done_q  <= 1'b0;
                            hold_q  <= 4'd0;
                            state_q <= S_IDLE;
                        end else begin
                            hold_q <= hold_q + 4'd1;
                        end
                    end
                end
                default: begin
                    mag_q   <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign min_tens     = mt_q;
    assign min_ones     = mo_q;
    assign sec_tens     = st_q;
    assign sec_ones     = so_q;
    assign magnetron_on = mag_q;
    assign done         = done_q;
    assign mode         = state_q;

endmodule

// File: tb/tb_cook_timer_controller.sv
// Directed bench for the cook timer: entry, countdown, done hold, door and stop handling.
module tb_cook_timer_controller;

    logic       clock = 1'b0;
    logic       clear, key_valid, start, stop_clear, door_closed, tick_1hz;
    logic [3:0] key_digit;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       magnetron_on, done;
    logic [2:0] mode;
    logic [15:0] tm;
    int checks = 0;
    int errors = 0;

    assign tm = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clock = ~clock;

    cook_timer_controller #(.DONE_HOLD(3)) dut (
        .clock(clock), .clear(clear), .key_valid(key_valid), .key_digit(key_digit),
        .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
        .tick_1hz(tick_1hz), .min_tens(min_tens), .min_ones(min_ones),
        .sec_tens(sec_tens), .sec_ones(sec_ones), .magnetron_on(magnetron_on),
        .done(done), .mode(mode)
    );

    // Stimulus helpers: drive on the falling edge, return on the next falling edge.
    task automatic key(input logic [3:0] d);
        key_valid = 1'b1; key_digit = d; @(negedge clock); key_valid = 1'b0;
    endtask
    task automatic pulse_start();
        start = 1'b1; @(negedge clock); start = 1'b0;
    endtask
    task automatic pulse_stop();
        stop_clear = 1'b1; @(negedge clock); stop_clear = 1'b0;
    endtask
    task automatic tick();
        tick_1hz = 1'b1; @(negedge clock); tick_1hz = 1'b0;
    endtask
    task automatic do_clear();
        clear = 1'b1; @(negedge clock); clear = 1'b0;
    endtask

    task automatic test_reset();
        do_clear();
        checks++; if (mode !== 3'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", mode); end
        checks++; if (tm !== 16'h0000) begin errors++; $display("FAIL reset_time got=%h exp=0000", tm); end
        checks++; if (magnetron_on !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_outs mag=%b done=%b exp=0,0", magnetron_on, done); end
        key(4'd12);
        checks++; if (mode !== 3'd0 || tm !== 16'h0000) begin errors++; $display("FAIL invalid_key mode=%0d time=%h exp=0,0000", mode, tm); end
    endtask

    task automatic test_cook_basic();
        key(4'd1); key(4'd3); key(4'd0);
        checks++; if (tm !== 16'h0130 || mode !== 3'd1) begin errors++; $display("FAIL basic_entry time=%h mode=%0d exp=0130,1", tm, mode); end
        pulse_start();
        checks++; if (mode !== 3'd2 || magnetron_on !== 1'b1 || tm !== 16'h0130) begin errors++; $display("FAIL basic_start mode=%0d mag=%b time=%h exp=2,1,0130", mode, magnetron_on, tm); end
        tick();
        checks++; if (tm !== 16'h0129) begin errors++; $display("FAIL basic_tick1 time=%h exp=0129", tm); end
        for (int i = 0; i < 30; i++) tick();
        checks++; if (tm !== 16'h0059 || mode !== 3'd2) begin errors++; $display("FAIL basic_borrow time=%h mode=%0d exp=0059,2", tm, mode); end
        pulse_stop(); pulse_stop();
        checks++; if (mode !== 3'd0 || tm !== 16'h0000) begin errors++; $display("FAIL basic_cancel mode=%0d time=%h exp=0,0000", mode, tm); end
    endtask

    task automatic test_done();
        key(4'd0); key(4'd0); key(4'd0); key(4'd5);
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        checks++; if (tm !== 16'h0001 || mode !== 3'd2 || magnetron_on !== 1'b1) begin errors++; $display("FAIL done_pre time=%h mode=%0d mag=%b exp=0001,2,1", tm, mode, magnetron_on); end
        tick();
        checks++; if (mode !== 3'd4 || done !== 1'b1 || magnetron_on !== 1'b0 || tm !== 16'h0000) begin errors++; $display("FAIL done_enter mode=%0d done=%b mag=%b time=%h exp=4,1,0,0000", mode, done, magnetron_on, tm); end
        tick(); tick();
        checks++; if (mode !== 3'd4 || done !== 1'b1) begin errors++; $display("FAIL done_hold mode=%0d done=%b exp=4,1", mode, done); end
        tick();
        checks++; if (mode !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL done_exit mode=%0d done=%b exp=0,0", mode, done); end
    endtask

    task automatic test_entry_limits();
        key(4'd0); key(4'd0); pulse_start();
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL zero_start mode=%0d exp=1", mode); end
        pulse_stop();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9); key(4'd7);
        checks++; if (tm !== 16'h9999 || mode !== 3'd1) begin errors++; $display("FAIL fifth_key time=%h mode=%0d exp=9999,1", tm, mode); end
        pulse_start(); tick();
        checks++; if (tm !== 16'h9998) begin errors++; $display("FAIL max_tick time=%h exp=9998", tm); end
        pulse_stop(); pulse_stop();
        key(4'd1); key(4'd7); key(4'd5); pulse_start(); tick();
        checks++; if (tm !== 16'h0174) begin errors++; $display("FAIL literal_tick time=%h exp=0174", tm); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (tm !== 16'h0169) begin errors++; $display("FAIL literal_borrow time=%h exp=0169", tm); end
        pulse_stop(); pulse_stop();
    endtask

    task automatic test_door();
        key(4'd4); key(4'd5); pulse_start();
        checks++; if (mode !== 3'd2 || tm !== 16'h0045) begin errors++; $display("FAIL door_cook mode=%0d time=%h exp=2,0045", mode, tm); end
        door_closed = 1'b0; tick();
        checks++; if (mode !== 3'd3 || tm !== 16'h0045 || magnetron_on !== 1'b0) begin errors++; $display("FAIL door_open mode=%0d time=%h mag=%b exp=3,0045,0", mode, tm, magnetron_on); end
        pulse_start();
        checks++; if (mode !== 3'd3 || magnetron_on !== 1'b0) begin errors++; $display("FAIL door_start_open mode=%0d mag=%b exp=3,0", mode, magnetron_on); end
        door_closed = 1'b1; @(negedge clock);
        pulse_start();
        checks++; if (mode !== 3'd2 || magnetron_on !== 1'b1) begin errors++; $display("FAIL door_resume mode=%0d mag=%b exp=2,1", mode, magnetron_on); end
        tick();
        checks++; if (tm !== 16'h0044) begin errors++; $display("FAIL door_tick time=%h exp=0044", tm); end
        pulse_stop(); pulse_stop();
    endtask

    task automatic test_stop();
        key(4'd2); key(4'd0); key(4'd0); pulse_start(); tick();
        checks++; if (tm !== 16'h0159) begin errors++; $display("FAIL stop_tick time=%h exp=0159", tm); end
        pulse_stop();
        checks++; if (mode !== 3'd3 || tm !== 16'h0159 || magnetron_on !== 1'b0) begin errors++; $display("FAIL stop_pause mode=%0d time=%h mag=%b exp=3,0159,0", mode, tm, magnetron_on); end
        tick();
        checks++; if (tm !== 16'h0159) begin errors++; $display("FAIL pause_frozen time=%h exp=0159", tm); end
        pulse_stop();
        checks++; if (mode !== 3'd0 || tm !== 16'h0000) begin errors++; $display("FAIL stop_cancel mode=%0d time=%h exp=0,0000", mode, tm); end
    endtask

    task automatic test_clear_mid();
        key(4'd1); key(4'd0); pulse_start();
        checks++; if (mode !== 3'd2 || tm !== 16'h0010) begin errors++; $display("FAIL clr_setup mode=%0d time=%h exp=2,0010", mode, tm); end
        do_clear();
        checks++; if (mode !== 3'd0 || tm !== 16'h0000 || magnetron_on !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL clr_mid mode=%0d time=%h mag=%b done=%b exp=0,0000,0,0", mode, tm, magnetron_on, done); end
        pulse_start();
        checks++; if (mode !== 3'd0 || magnetron_on !== 1'b0) begin errors++; $display("FAIL clr_start mode=%0d mag=%b exp=0,0", mode, magnetron_on); end
    endtask

    initial begin
        clear = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
        stop_clear = 1'b0; door_closed = 1'b1; tick_1hz = 1'b0;
        @(negedge clock);
        test_reset();
        test_cook_basic();
        test_done();
        test_entry_limits();
        test_door();
        test_stop();
        test_clear_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
